// File: rtl/johnson_decoder.sv
// johnson_decoder: checks, decodes and tracks lock on a sampled Johnson-coded counter word
module johnson_decoder #(
  parameter int N = 9,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W = 8,
  parameter bit ALLOW_HOLD = 1'b0,
  localparam int W = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rset_n,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  input  logic             err_clr,
  output logic [W-1:0]     count_out,
  output logic             count_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0] LAST = W'(2 * N - 1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_CNT);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t state, state_d;
  logic [RW-1:0] run, run_d;
  logic [W-1:0] ref_idx, ref_d, count_d, k, succ, ones;
  logic [N-2:0] edges;
  logic legal, hold, valid_d, code_err_d, seq_err_d, err;
  logic [ERR_W-1:0] err_cnt_d;
  // legality from adjacent-bit transitions, index from the count of ones and the low bit
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + W'(code_in[i]);
    edges = code_in[N-1:1] ^ code_in[N-2:0];
    legal = (edges & (edges - (N-1)'(1))) == '0;
    k = code_in[0] ? W'(2 * N) - ones : ones;
    succ = ref_idx == LAST ? '0 : ref_idx + W'(1);
    hold = ALLOW_HOLD && k == ref_idx;
  end
  // next-state: lock FSM, reference tracking, pulses and saturating error count
  always_comb begin
    state_d = state;
    run_d = run;
    ref_d = ref_idx;
    count_d = count_out;
    valid_d = 1'b0;
    code_err_d = 1'b0;
    seq_err_d = 1'b0;
    if (code_valid) begin
      if (!legal) begin
        code_err_d = 1'b1;
        state_d = HUNT;
        run_d = '0;
      end else begin
        valid_d = 1'b1;
        count_d = k;
        ref_d = k;
        if (state == HUNT) begin
          state_d = SYNC;
          run_d = '0;
        end else if (k == succ) begin
          if (state == SYNC) begin
            run_d = run + RW'(1);
            state_d = run_d == LOCK_RUN ? LOCKED : SYNC;
          end
        end else if (!hold) begin
          seq_err_d = 1'b1;
          state_d = SYNC;
          run_d = '0;
        end
      end
    end
    err = code_err_d | seq_err_d;
    err_cnt_d = err_clr ? ERR_W'(err) : (err && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rset_n)
    if (!rset_n) begin
      state <= HUNT;
      run <= '0;
      ref_idx <= '0;
      count_out <= '0;
      count_valid <= 1'b0;
      code_err <= 1'b0;
      seq_err <= 1'b0;
      locked <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_d;
      run <= run_d;
      ref_idx <= ref_d;
      count_out <= count_d;
      count_valid <= valid_d;
      code_err <= code_err_d;
      seq_err <= seq_err_d;
      locked <= state_d == LOCKED;
      err_cnt <= err_cnt_d;
    end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: randomized and directed checks of johnson_decoder against a table-driven model
module tb_johnson_decoder;
  logic clk = 1'b0, rset_n = 1'b0, code_valid = 1'b0, err_clr = 1'b0;
  logic [8:0] code_in = '0;
  logic [4:0] co [3];
  logic cv [3], ce [3], se [3], lk [3];
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;
  logic [16:0] obs [3];
  int checks = 0, errors = 0;
  logic [8:0] jw [18];
  int m_count [3], m_ref [3], m_run [3], m_err [3];
  bit m_have [3], m_lk [3], m_cv [3], m_ce [3], m_se [3];
  int cur;

  always #5 clk = ~clk;

  johnson_decoder u_dut (.clk(clk), .rset_n(rset_n), .code_in(code_in), .code_valid(code_valid),
    .err_clr(err_clr), .count_out(co[0]), .count_valid(cv[0]), .code_err(ce[0]), .seq_err(se[0]),
    .locked(lk[0]), .err_cnt(ec0));
  johnson_decoder #(.ALLOW_HOLD(1'b1)) u_hold (.clk(clk), .rset_n(rset_n), .code_in(code_in),
    .code_valid(code_valid), .err_clr(err_clr), .count_out(co[1]), .count_valid(cv[1]),
    .code_err(ce[1]), .seq_err(se[1]), .locked(lk[1]), .err_cnt(ec1));
  johnson_decoder #(.ERR_W(2)) u_sat (.clk(clk), .rset_n(rset_n), .code_in(code_in),
    .code_valid(code_valid), .err_clr(err_clr), .count_out(co[2]), .count_valid(cv[2]),
    .code_err(ce[2]), .seq_err(se[2]), .locked(lk[2]), .err_cnt(ec2));

  assign obs[0] = {co[0], cv[0], ce[0], se[0], lk[0], ec0};
  assign obs[1] = {co[1], cv[1], ce[1], se[1], lk[1], ec1};
  assign obs[2] = {co[2], cv[2], ce[2], se[2], lk[2], 6'd0, ec2};

  function automatic int idx_of(logic [8:0] w);
    for (int k = 0; k < 18; k++) if (jw[k] == w) return k;
    return -1;
  endfunction

  function automatic logic [16:0] exp_vec(int i);
    return {5'(m_count[i]), m_cv[i], m_ce[i], m_se[i], m_lk[i], 8'(m_err[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0; m_ref[i] = 0; m_run[i] = 0; m_err[i] = 0;
      m_have[i] = 0; m_lk[i] = 0; m_cv[i] = 0; m_ce[i] = 0; m_se[i] = 0;
    end
  endtask

  task automatic step(logic [8:0] w, logic v, logic c);
    int idx, emax;
    bit hold;
    code_in = w; code_valid = v; err_clr = c;
    @(posedge clk);
    idx = idx_of(w);
    for (int i = 0; i < 3; i++) begin
      hold = (i == 1);
      emax = (i == 2) ? 3 : 255;
      m_cv[i] = 0; m_ce[i] = 0; m_se[i] = 0;
      if (v) begin
        if (idx < 0) begin
          m_ce[i] = 1; m_have[i] = 0; m_run[i] = 0; m_lk[i] = 0;
        end else begin
          m_cv[i] = 1;
          m_count[i] = idx;
          if (!m_have[i]) begin
            m_have[i] = 1; m_run[i] = 0;
          end else if (idx == (m_ref[i] + 1) % 18) begin
            m_run[i]++;
            if (m_run[i] >= 4) m_lk[i] = 1;
          end else if (!(hold && idx == m_ref[i])) begin
            m_se[i] = 1; m_run[i] = 0; m_lk[i] = 0;
          end
          m_ref[i] = idx;
        end
      end
      if (c) m_err[i] = (m_ce[i] || m_se[i]) ? 1 : 0;
      else if ((m_ce[i] || m_se[i]) && m_err[i] < emax) m_err[i]++;
    end
    if (v && idx >= 0) cur = idx;
    #1;
  endtask

  function automatic logic [8:0] bad_word();
    logic [8:0] w;
    do w = 9'($urandom); while (idx_of(w) >= 0);
    return w;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 17'd0) begin errors++; $display("FAIL reset inst%0d got %h exp 0", i, obs[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (obs[0] !== 17'd0) begin errors++; $display("FAIL reset_hold got %h exp 0", obs[0]); end
    rset_n = 1'b1;
  endtask

  task automatic test_sequence();
    for (int n = 0; n < 40; n++) begin
      step(jw[n % 18], 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL sequence n%0d inst%0d got %h exp %h", n, i, obs[i], exp_vec(i)); end
      end
      if (n == 3 || n == 4) begin
        checks++;
        if (lk[0] !== (n == 4)) begin errors++; $display("FAIL lock_point n%0d got %b exp %b", n, lk[0], n == 4); end
      end
      checks++;
      if (co[0] !== 5'(n % 18)) begin errors++; $display("FAIL seq_count n%0d got %0d exp %0d", n, co[0], n % 18); end
    end
  endtask

  task automatic test_illegal();
    step(9'h155, 1'b1, 1'b0);
    checks++;
    if ({ce[0], co[0], lk[0], ec0} !== {1'b1, 5'd3, 1'b0, 8'd1}) begin
      errors++; $display("FAIL illegal got ce%b co%0d lk%b ec%0d exp ce1 co3 lk0 ec1", ce[0], co[0], lk[0], ec0);
    end
    for (int n = 1; n <= 5; n++) begin
      step(jw[(cur + 1) % 18], 1'b1, 1'b0);
      checks++;
      if (lk[0] !== (n == 5)) begin errors++; $display("FAIL relock n%0d got %b exp %b", n, lk[0], n == 5); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL illegal_model inst%0d got %h exp %h", i, obs[i], exp_vec(i)); end
      end
    end
  endtask

  task automatic test_skip();
    do step(jw[(cur + 1) % 18], 1'b1, 1'b0); while (cur != 3);
    step(9'h1F0, 1'b1, 1'b0);
    checks++;
    if ({se[0], co[0], lk[0]} !== {1'b1, 5'd5, 1'b0}) begin
      errors++; $display("FAIL skip got se%b co%0d lk%b exp se1 co5 lk0", se[0], co[0], lk[0]);
    end
    for (int n = 6; n <= 9; n++) begin
      step(jw[n], 1'b1, 1'b0);
      checks++;
      if ({se[0], lk[0]} !== {1'b0, n == 9}) begin errors++; $display("FAIL skip_relock k%0d got se%b lk%b exp se0 lk%b", n, se[0], lk[0], n == 9); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL skip_model inst%0d got %h exp %h", i, obs[i], exp_vec(i)); end
      end
    end
  endtask

  task automatic test_hold();
    step(9'h1FF, 1'b1, 1'b0);
    checks++;
    if (se[0] !== 1'b1) begin errors++; $display("FAIL hold_strict got se%b exp 1", se[0]); end
    checks++;
    if ({se[1], cv[1], co[1], lk[1]} !== {1'b0, 1'b1, 5'd9, 1'b1}) begin
      errors++; $display("FAIL hold_allowed got se%b cv%b co%0d lk%b exp se0 cv1 co9 lk1", se[1], cv[1], co[1], lk[1]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL hold_model inst%0d got %h exp %h", i, obs[i], exp_vec(i)); end
    end
  endtask

  task automatic test_saturation();
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    step(9'h000, 1'b0, 1'b1);
    checks++;
    if ({ec0, ec1, ec2} !== 18'd0) begin errors++; $display("FAIL err_clr got %0d %0d %0d exp 0", ec0, ec1, ec2); end
    for (int n = 0; n < 5; n++) begin
      step(bad_word(), 1'b1, 1'b0);
      checks++;
      if (ec2 !== 2'(exp_sat[n])) begin errors++; $display("FAIL saturate n%0d got %0d exp %0d", n, ec2, exp_sat[n]); end
    end
    step(bad_word(), 1'b1, 1'b1);
    checks++;
    if ({ec0, ec2} !== {8'd1, 2'd1}) begin errors++; $display("FAIL clr_with_err got %0d %0d exp 1 1", ec0, ec2); end
  endtask

  task automatic test_random();
    logic [8:0] w;
    logic v;
    for (int n = 0; n < 600; n++) begin
      v = 1'b1;
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 5: w = jw[(cur + 1) % 18];
        6: w = bad_word();
        7, 8: w = jw[cur];
        9: w = jw[$urandom_range(0, 17)];
        default: begin w = 9'($urandom); v = 1'b0; end
      endcase
      step(w, v, $urandom_range(0, 15) == 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL random n%0d inst%0d got %h exp %h", n, i, obs[i], exp_vec(i)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 6; n++) step(jw[(cur + 1) % 18], 1'b1, 1'b0);
    #2 rset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 17'd0) begin errors++; $display("FAIL reset_mid inst%0d got %h exp 0", i, obs[i]); end
    end
    rset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step(jw[(cur + 1) % 18], 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin errors++; $display("FAIL resume n%0d inst%0d got %h exp %h", n, i, obs[i], exp_vec(i)); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 18; k++) jw[k] = (k <= 9) ? ~(9'h1FF >> k) : (9'h1FF >> (k - 9));
    model_reset();
    cur = 0;
    #12;
    test_reset();
    test_sequence();
    test_illegal();
    test_skip();
    test_hold();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
